imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive loader grants while fetch waits.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port f_req  in  1  fetch requests a read; held with f_addr until f_gnt.
REQ-005 SHALL have port f_addr  in  32  fetch read address.
REQ-006 SHALL have port f_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-007 SHALL have port f_valid  out  1  one-cycle pulse: f_data holds the fetched instruction.
REQ-008 SHALL have port f_data  out  32  fetched instruction, registered.
REQ-009 SHALL have port l_req  in  1  loader requests a write; held with l_addr/l_wdata until l_gnt.
REQ-010 SHALL have port l_addr  in  32  loader write address.
REQ-011 SHALL have port l_wdata  in  32  loader write data.
REQ-012 SHALL have port l_gnt  out  1  one-cycle pulse: loader request accepted.
REQ-013 SHALL have port l_done  out  1  one-cycle pulse: write committed.
REQ-014 SHALL have ports mem_rd out 1, mem_wn out 1, mem_address out 32, mem_write_data out 32, mem_read_data in 32: instruction memory port, registered outputs, read data valid one cycle after mem_rd.

Function
REQ-015 SHALL run FSM states IDLE, FETCH, LOAD; exactly one memory access per cycle, never mem_rd and mem_wn together.
REQ-016 SHALL, at each rising edge with any request high, pick a winner and enter FETCH or LOAD for the next cycle; with no request, enter IDLE.
REQ-017 SHALL, in FETCH, drive f_gnt=1, mem_rd=1, mem_wn=0, mem_address=f_addr captured at the decision edge.
REQ-018 SHALL, in LOAD, drive l_gnt=1, mem_wn=1, mem_rd=0, mem_address=l_addr, mem_write_data=l_wdata captured at the decision edge.
REQ-019 SHALL register mem_read_data into f_data and pulse f_valid the cycle after each FETCH cycle; request edge to f_valid = 2 cycles.
REQ-020 SHALL pulse l_done the cycle after each LOAD cycle.
REQ-021 SHALL chain FETCH/LOAD directly into the next grant without an IDLE cycle (back-to-back throughput 1 access/cycle).
REQ-022 SHALL, on contention, grant loader unless burst counter equals MAX_BURST, then grant fetch once.
REQ-023 SHALL increment burst counter on each loader grant while f_req high, saturate at MAX_BURST, clear on any fetch grant or when f_req low.
REQ-024 SHALL treat a request withdrawn before its grant edge as never made; no grant, no valid/done.
REQ-025 SHALL hold f_data at its last value when f_valid=0; mem_address/mem_write_data hold last value in IDLE.

Reset
REQ-026 SHALL, on reset assertion at any time, immediately force state IDLE, burst counter 0, and f_gnt, f_valid, l_gnt, l_done, mem_rd, mem_wn to 0, f_data, mem_address, mem_write_data to 0.
REQ-027 SHALL discard any access in flight at reset; no f_valid or l_done for it after release.
REQ-028 SHALL make the first grant possible at the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with ROUND_ROBIN_EN defined, replace REQ-022/REQ-023 by strict alternation on contention (winner = requester not granted last; loader first after reset), burst counter unused.
REQ-030 SHALL, without ROUND_ROBIN_EN, use fixed loader priority with MAX_BURST starvation guard.

Verification
REQ-031 SHALL cover: f_req=1, f_addr=0x10, memory word 0x00000013 -> f_gnt next cycle with mem_rd=1/mem_address=0x10, f_valid+f_data=0x00000013 one cycle later.
REQ-032 SHALL cover: l_req=1, l_addr=0x20, l_wdata=0xDEADBEEF, then fetch 0x20 -> mem_wn pulse, l_done, fetch returns 0xDEADBEEF.
REQ-033 SHALL cover: f_req and l_req held high 12 cycles, MAX_BURST=4 -> grant pattern L,L,L,L,F repeating; never mem_rd with mem_wn.
REQ-034 SHALL cover: ROUND_ROBIN_EN, both requests held -> grants alternate L,F,L,F.
REQ-035 SHALL cover: reset asserted mid-FETCH (between grant and valid) -> all outputs 0 immediately, no f_valid after release.
REQ-036 SHALL cover: f_req dropped one cycle before grant while loader busy -> no f_gnt, no f_valid.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: a single memory port shared between the fetch
// unit (reads) and the program loader (writes).
// Optional feature: define ROUND_ROBIN_EN to replace the loader-priority /
// burst-limit policy with strict alternation on contention.
// The memory's read data is sampled at the edge that closes the FETCH cycle,
// so f_valid/f_data appear one cycle after mem_rd.
module imem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_data,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_done,
    output logic        mem_rd,
    output logic        mem_wn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t state_q, state_d;

`ifdef ROUND_ROBIN_EN
    logic last_f_q, last_f_d;

    // Alternate on contention; the requester not granted last wins.
    always_comb begin
        state_d  = IDLE;
        last_f_d = last_f_q;
        if (f_req && l_req) begin
            state_d = last_f_q ? LOAD : FETCH;
        end else if (l_req) begin
            state_d = LOAD;
        end else if (f_req) begin
            state_d = FETCH;
        end
        if (state_d == FETCH) begin
            last_f_d = 1'b1;
        end else if (state_d == LOAD) begin
            last_f_d = 1'b0;
        end
    end

    // Last-grant flag; reset value makes the loader win the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_f_q <= 1'b1;
        end else begin
            last_f_q <= last_f_d;
        end
    end
`else
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst_q, burst_d;

    // Loader wins contention until it has taken MAX_BURST grants in a row
    // over a waiting fetch; then fetch gets exactly one grant.
    always_comb begin
        state_d = IDLE;
        burst_d = '0;
        if (f_req && l_req) begin
            if (burst_q == BW'(MAX_BURST)) begin
                state_d = FETCH;
            end else begin
                state_d = LOAD;
                burst_d = burst_q + BW'(1);
            end
        end else if (l_req) begin
            state_d = LOAD;
        end else if (f_req) begin
            state_d = FETCH;
        end
    end

    // Burst counter of loader grants taken while fetch was waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    // State register plus all registered outputs, decoded from the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            f_gnt          <= 1'b0;
            l_gnt          <= 1'b0;
            mem_rd         <= 1'b0;
            mem_wn         <= 1'b0;
            f_valid        <= 1'b0;
            l_done         <= 1'b0;
            f_data         <= 32'h0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            state_q <= state_d;
            f_gnt   <= (state_d == FETCH);
            mem_rd  <= (state_d == FETCH);
            l_gnt   <= (state_d == LOAD);
            mem_wn  <= (state_d == LOAD);
            f_valid <= (state_q == FETCH);
            l_done  <= (state_q == LOAD);
            if (state_q == FETCH) begin
                f_data <= mem_read_data;
            end
            if (state_d == FETCH) begin
                mem_address <= f_addr;
            end else if (state_d == LOAD) begin
                mem_address    <= l_addr;
                mem_write_data <= l_wdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios plus a randomized run
// checked against a requester-level reference model.
module tb_imem_arbiter;

    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt, f_valid;
    logic [31:0] f_data;
    logic        l_req;
    logic [31:0] l_addr, l_wdata;
    logic        l_gnt, l_done;
    logic        mem_rd, mem_wn;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    imem_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_done(l_done),
        .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory: read data returned within the access cycle, write at its end.
    always_comb begin
        mem_read_data = 32'h0;
        for (int i = 0; i < DEPTH; i++)
            if (mem_address == 32'(i * 4)) mem_read_data = mem[i];
    end

    always @(posedge clk)
        if (mem_wn)
            for (int i = 0; i < DEPTH; i++)
                if (mem_address == 32'(i * 4)) mem[i] <= mem_write_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; f_req = 1'b0; l_req = 1'b0;
        f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;
        tick(); tick();
        total_cnt++;
        if ({f_gnt, f_valid, l_gnt, l_done, mem_rd, mem_wn} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {f_gnt, f_valid, l_gnt, l_done, mem_rd, mem_wn});
        else pass_cnt++;
        total_cnt++;
        if ({f_data, mem_address, mem_write_data} !== 96'h0)
            $display("FAIL reset_data: got %h %h %h want 0", f_data, mem_address, mem_write_data);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_fetch_basic();
        f_addr = 32'h10; f_req = 1'b1;
        tick();
        total_cnt++;
        if ({f_gnt, mem_rd, mem_wn, l_gnt} !== 4'b1100)
            $display("FAIL fetch_gnt: got gnt/rd/wn/lgnt=%b want 1100", {f_gnt, mem_rd, mem_wn, l_gnt});
        else pass_cnt++;
        total_cnt++;
        if (mem_address !== 32'h10) $display("FAIL fetch_addr: got %h want 00000010", mem_address);
        else pass_cnt++;
        f_req = 1'b0; f_addr = 32'h30;
        tick();
        total_cnt++;
        if ({f_valid, f_gnt} !== 2'b10 || f_data !== 32'h13)
            $display("FAIL fetch_valid: got valid=%b gnt=%b data=%h want 1 0 00000013", f_valid, f_gnt, f_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (f_valid !== 1'b0 || f_data !== 32'h13 || mem_address !== 32'h10 || mem_rd !== 1'b0)
            $display("FAIL idle_hold: got valid=%b data=%h addr=%h rd=%b want 0 00000013 00000010 0",
                     f_valid, f_data, mem_address, mem_rd);
        else pass_cnt++;
    endtask

    task automatic test_load_then_fetch();
        l_addr = 32'h20; l_wdata = 32'hDEADBEEF; l_req = 1'b1;
        tick();
        total_cnt++;
        if ({l_gnt, mem_wn, mem_rd, f_gnt} !== 4'b1100 || mem_address !== 32'h20 || mem_write_data !== 32'hDEADBEEF)
            $display("FAIL load_gnt: got gnt/wn/rd/fgnt=%b addr=%h wdata=%h want 1100 00000020 deadbeef",
                     {l_gnt, mem_wn, mem_rd, f_gnt}, mem_address, mem_write_data);
        else pass_cnt++;
        l_req = 1'b0; f_req = 1'b1; f_addr = 32'h20;
        tick();
        total_cnt++;
        if ({l_done, f_gnt, mem_rd, mem_wn} !== 4'b1110 || mem_address !== 32'h20)
            $display("FAIL load_done_chain: got done/fgnt/rd/wn=%b addr=%h want 1110 00000020",
                     {l_done, f_gnt, mem_rd, mem_wn}, mem_address);
        else pass_cnt++;
        f_req = 1'b0;
        tick();
        total_cnt++;
        if (f_valid !== 1'b1 || f_data !== 32'hDEADBEEF || l_done !== 1'b0)
            $display("FAIL load_readback: got valid=%b data=%h done=%b want 1 deadbeef 0", f_valid, f_data, l_done);
        else pass_cnt++;
        ref_mem[8] = 32'hDEADBEEF;
        tick();
    endtask

    task automatic test_contention();
        logic exp_f, prev_f;
        pulse_reset();
        prev_f = 1'b0;
        f_req = 1'b1; f_addr = 32'h10; l_req = 1'b1; l_addr = 32'h40;
        for (int k = 0; k < 12; k++) begin
            l_wdata = $urandom;
`ifdef ROUND_ROBIN_EN
            exp_f = (k % 2) == 1;
`else
            exp_f = (k % (MB + 1)) == MB;
`endif
            tick();
            total_cnt++;
            if (f_gnt !== exp_f || l_gnt !== !exp_f || (mem_rd && mem_wn) !== 1'b0)
                $display("FAIL contention_grant[%0d]: got f=%b l=%b rd&wn=%b want f=%b l=%b 0",
                         k, f_gnt, l_gnt, mem_rd && mem_wn, exp_f, !exp_f);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (f_valid !== prev_f || l_done !== !prev_f || (prev_f && f_data !== 32'h13))
                    $display("FAIL contention_resp[%0d]: got valid=%b done=%b data=%h want %b %b",
                             k, f_valid, l_done, f_data, prev_f, !prev_f);
                else pass_cnt++;
            end
            if (!exp_f) ref_mem[16] = l_wdata;
            prev_f = exp_f;
        end
        f_req = 1'b0; l_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_fetch();
        f_req = 1'b1; f_addr = 32'h10;
        tick();
        total_cnt++;
        if (f_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b want 1", f_gnt);
        else pass_cnt++;
        f_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({f_gnt, f_valid, l_gnt, l_done, mem_rd, mem_wn} !== 6'b0 ||
            {f_data, mem_address, mem_write_data} !== 96'h0)
            $display("FAIL midrst_async: got ctrl=%b data=%h addr=%h wdata=%h want 0",
                     {f_gnt, f_valid, l_gnt, l_done, mem_rd, mem_wn}, f_data, mem_address, mem_write_data);
        else pass_cnt++;
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({f_valid, l_done, f_gnt} !== 3'b000)
                $display("FAIL midrst_after[%0d]: got valid/done/gnt=%b want 000", k, {f_valid, l_done, f_gnt});
            else pass_cnt++;
        end
    endtask

    task automatic test_withdraw();
        f_req = 1'b1; f_addr = 32'h10; l_req = 1'b1; l_addr = 32'h44; l_wdata = 32'h5A5A0001;
        tick();
        total_cnt++;
        if ({l_gnt, f_gnt} !== 2'b10) $display("FAIL withdraw_first: got l/f=%b want 10", {l_gnt, f_gnt});
        else pass_cnt++;
        ref_mem[17] = l_wdata;
        f_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if ({f_gnt, f_valid, l_gnt} !== 3'b001)
                $display("FAIL withdraw[%0d]: got fgnt/fvalid/lgnt=%b want 001", k, {f_gnt, f_valid, l_gnt});
            else pass_cnt++;
        end
        l_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        logic win_f, win_l, exp_valid, exp_done, last_f;
        logic [31:0] exp_data, last_data;
        int streak;
        pulse_reset();
        streak = 0; last_f = 1'b1; exp_valid = 1'b0; exp_done = 1'b0;
        exp_data = 32'h0; last_data = 32'h0;
        f_req = 1'b0; l_req = 1'b0;
        for (int k = 0; k < 400; k++) begin
`ifdef ROUND_ROBIN_EN
            win_f = f_req && (!l_req || !last_f);
`else
            win_f = f_req && (!l_req || streak == MB);
`endif
            win_l = l_req && !win_f;
            tick();
            total_cnt++;
            if ({f_gnt, l_gnt, mem_rd, mem_wn} !== {win_f, win_l, win_f, win_l})
                $display("FAIL rand_grant[%0d]: got fgnt/lgnt/rd/wn=%b want %b",
                         k, {f_gnt, l_gnt, mem_rd, mem_wn}, {win_f, win_l, win_f, win_l});
            else pass_cnt++;
            if (win_f || win_l) begin
                total_cnt++;
                if (mem_address !== (win_f ? f_addr : l_addr) || (win_l && mem_write_data !== l_wdata))
                    $display("FAIL rand_addr[%0d]: got addr=%h wdata=%h want addr=%h",
                             k, mem_address, mem_write_data, win_f ? f_addr : l_addr);
                else pass_cnt++;
            end
            total_cnt++;
            if (f_valid !== exp_valid || l_done !== exp_done ||
                f_data !== (exp_valid ? exp_data : last_data))
                $display("FAIL rand_resp[%0d]: got valid=%b done=%b data=%h want %b %b %h",
                         k, f_valid, l_done, f_data, exp_valid, exp_done, exp_valid ? exp_data : last_data);
            else pass_cnt++;
            if (exp_valid) last_data = exp_data;
            exp_valid = win_f;
            exp_done  = win_l;
            if (win_f) exp_data = ref_mem[f_addr >> 2];
            if (win_l) ref_mem[l_addr >> 2] = l_wdata;
            if (win_l && f_req) streak = (streak < int'(MB)) ? streak + 1 : int'(MB);
            else streak = 0;
            if (win_f) last_f = 1'b1;
            else if (win_l) last_f = 1'b0;
            // Requesters: finish, start, or occasionally withdraw a pending request.
            if (win_f || !f_req) begin
                f_req  = ($urandom_range(0, 2) != 0);
                f_addr = 32'(32'h80 + 4 * $urandom_range(0, 7));
            end else if ($urandom_range(0, 9) == 0) begin
                f_req = 1'b0;
            end
            if (win_l || !l_req) begin
                l_req   = ($urandom_range(0, 2) != 0);
                l_addr  = 32'(32'h80 + 4 * $urandom_range(0, 7));
                l_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                l_req = 1'b0;
            end
        end
        f_req = 1'b0; l_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[4] = 32'h00000013;
        ref_mem[4] = 32'h00000013;
        test_reset();
        test_fetch_basic();
        test_load_then_fetch();
        test_contention();
        test_reset_mid_fetch();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
